// File: rtl/heavy_hash_result_checker.sv
// Collects four 64-bit heavy_hash words into a 256-bit hash, pairs it with a nonce
// from the core's nonce FIFO, and reports hashes at or below the target to the host.
module heavy_hash_result_checker #(
  parameter int BUF_DEPTH    = 8,
  parameter int STALL_MARGIN = 4,
  parameter int NONCE_LAT    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  heavy_hash_out_data,
  input  logic         heavy_hash_out_we,
  output logic         heavy_hash_out_re,
  input  logic [31:0]  nonce,
  input  logic         nonce_fifo_empty,
  output logic         nonce_fifo_re,
  input  logic         target_we,
  input  logic [1:0]   target_addr,
  input  logic [63:0]  target_din,
  output logic         found_valid,
  input  logic         found_ack,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  hash_count,
  output logic [31:0]  found_count,
  output logic         overflow_err
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(STALL_MARGIN);
  localparam logic [7:0]    LAT_LAST = 8'(NONCE_LAT - 1);

  typedef enum logic [2:0] {COLLECT, COMPARE, NONCE_RD, NONCE_WAIT, REPORT} state_e;

  state_e         state_q, state_d;
  logic [63:0]    mem_q [BUF_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           full, empty, push, pop;
  logic           stall_q, ovf_q;
  logic [1:0]     word_idx_q;
  logic [255:0]   hash_q, target_q;
  logic           win_q, valid_q;
  logic [7:0]     wait_q;
  logic [31:0]    nonce_q, hash_cnt_q, found_cnt_q;

  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign push  = heavy_hash_out_we && !full;
  assign pop   = (state_q == COLLECT) && !empty;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    state_d       = state_q;
    nonce_fifo_re = 1'b0;
    case (state_q)
      COLLECT:    if (pop && word_idx_q == 2'd3) state_d = COMPARE;
      COMPARE:    state_d = NONCE_RD;
      NONCE_RD: begin
        if (!nonce_fifo_empty) begin
          nonce_fifo_re = 1'b1;
          state_d       = NONCE_WAIT;
        end
      end
      NONCE_WAIT: if (wait_q == LAT_LAST) state_d = win_q ? REPORT : COLLECT;
      REPORT:     if (found_ack && valid_q) state_d = COLLECT;
      default:    state_d = COLLECT;
    endcase
  end

  // Buffer storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= heavy_hash_out_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
      ovf_q       <= 1'b0;
      word_idx_q  <= '0;
      hash_q      <= '0;
      target_q    <= '1;
      win_q       <= 1'b0;
      valid_q     <= 1'b0;
      wait_q      <= '0;
      nonce_q     <= '0;
      hash_cnt_q  <= '0;
      found_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= ((DEPTH_C - cnt_d) <= MARGIN_C);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (heavy_hash_out_we && full) ovf_q <= 1'b1;
      if (target_we) target_q[{target_addr, 6'd0} +: 64] <= target_din;
      if (pop) begin
        rd_ptr_q                       <= rd_ptr_q + 1'b1;
        hash_q[{word_idx_q, 6'd0} +: 64] <= mem_q[rd_ptr_q];
        word_idx_q                     <= word_idx_q + 2'd1;
      end
      case (state_q)
        COMPARE: begin
          win_q      <= (hash_q <= target_q);
          hash_cnt_q <= hash_cnt_q + 32'd1;
        end
        NONCE_RD: wait_q <= '0;
        NONCE_WAIT: begin
          wait_q <= wait_q + 8'd1;
          if (wait_q == LAT_LAST) begin
            nonce_q <= nonce;
            valid_q <= win_q;
          end
        end
        REPORT: begin
          if (found_ack && valid_q) begin
            valid_q     <= 1'b0;
            found_cnt_q <= found_cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign heavy_hash_out_re = stall_q;
  assign overflow_err      = ovf_q;
  assign found_valid       = valid_q;
  assign found_nonce       = nonce_q;
  assign found_hash        = hash_q;
  assign hash_count        = hash_cnt_q;
  assign found_count       = found_cnt_q;
endmodule

// File: tb/tb_heavy_hash_result_checker.sv
// Bench for heavy_hash_result_checker: vector table, hand-written corner sequences and
// a randomized phase, all scored against a word/nonce-stream reference model.
module tb_heavy_hash_result_checker;
  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  heavy_hash_out_data;
  logic         heavy_hash_out_we;
  logic         heavy_hash_out_re;
  logic [31:0]  nonce;
  logic         nonce_fifo_empty;
  logic         nonce_fifo_re;
  logic         target_we;
  logic [1:0]   target_addr;
  logic [63:0]  target_din;
  logic         found_valid;
  logic         found_ack;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic [31:0]  hash_count;
  logic [31:0]  found_count;
  logic         overflow_err;

  heavy_hash_result_checker dut (
    .clk(clk), .rst(rst),
    .heavy_hash_out_data(heavy_hash_out_data), .heavy_hash_out_we(heavy_hash_out_we),
    .heavy_hash_out_re(heavy_hash_out_re),
    .nonce(nonce), .nonce_fifo_empty(nonce_fifo_empty), .nonce_fifo_re(nonce_fifo_re),
    .target_we(target_we), .target_addr(target_addr), .target_din(target_din),
    .found_valid(found_valid), .found_ack(found_ack), .found_nonce(found_nonce),
    .found_hash(found_hash), .hash_count(hash_count), .found_count(found_count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  w0, w1, w2, w3;
    logic [255:0] tgt;
    logic [31:0]  n;
    bit           win;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int re_pulses = 0;
  int hashes_m = 0;
  int founds_m = 0;
  int rise_cyc = 0;
  int ack_wait = 0;
  bit prev_valid = 1'b0;
  bit re_pre = 1'b0;
  bit auto_drive = 1'b1;
  bit auto_ack = 1'b1;
  bit honor_stall = 1'b1;
  bit hold_empty = 1'b0;
  bit rand_empty = 1'b0;
  bit rand_ack = 1'b0;
  logic [63:0]  wq[$];
  logic [31:0]  nq[$];
  logic [63:0]  mw[$];
  logic [31:0]  mn[$];
  logic [31:0]  en[$];
  logic [255:0] eh[$];
  logic [255:0] tgt_m = '1;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: every four accepted words form one hash, low word first, and
  // consume the next nonce; a hash at or below the current target is a winner.
  function automatic void model_word(input logic [63:0] w);
    logic [255:0] h;
    logic [31:0]  n;
    mw.push_back(w);
    if (mw.size() == 4) begin
      h = {mw[3], mw[2], mw[1], mw[0]};
      n = (mn.size() > 0) ? mn.pop_front() : 32'h0;
      hashes_m++;
      if (h <= tgt_m) begin
        en.push_back(n);
        eh.push_back(h);
      end
      mw.delete();
    end
  endfunction

  function automatic void model_reset();
    mw.delete(); mn.delete(); en.delete(); eh.delete(); nq.delete(); wq.delete();
    hashes_m = 0; founds_m = 0; re_pulses = 0; tgt_m = '1;
  endfunction

  function automatic void sync_empty();
    nonce_fifo_empty = hold_empty || (nq.size() == 0);
  endfunction

  task automatic check_result();
    if (eh.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_win: nonce %0h hash %0h while no winner is pending", found_nonce, found_hash);
    end else begin
      chk("found_nonce", {224'd0, found_nonce}, {224'd0, en.pop_front()});
      chk("found_hash", found_hash, eh.pop_front());
      founds_m++;
    end
  endtask

  // One clock: sample the FIFO read pulse mid-cycle, then update all inputs #1 after the edge.
  task automatic tick();
    @(negedge clk);
    re_pre = nonce_fifo_re;
    if (nonce_fifo_re) re_pulses++;
    @(posedge clk);
    #1;
    cyc++;
    target_we = 1'b0;
    if (re_pre && nq.size() > 0) nonce = nq.pop_front();
    if (found_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = found_valid;
    if (found_ack) found_ack = 1'b0;
    else if (auto_ack && found_valid) begin
      if (ack_wait > 0) ack_wait--;
      else begin
        check_result();
        found_ack = 1'b1;
        ack_wait = rand_ack ? $urandom_range(0, 3) : 0;
      end
    end
    if (rand_empty) hold_empty = ($urandom_range(0, 3) == 0);
    sync_empty();
    if (auto_drive) begin
      if (wq.size() > 0 && (!honor_stall || !heavy_hash_out_re)) begin
        heavy_hash_out_data = wq.pop_front();
        heavy_hash_out_we = 1'b1;
        model_word(heavy_hash_out_data);
      end else begin
        heavy_hash_out_we = 1'b0;
      end
    end
  endtask

  task automatic set_target(input logic [255:0] t);
    for (int a = 0; a < 4; a++) begin
      target_we = 1'b1;
      target_addr = 2'(a);
      target_din = t[a*64 +: 64];
      tick();
    end
    tgt_m = t;
  endtask

  task automatic queue_nonce(input logic [31:0] n);
    nq.push_back(n);
    mn.push_back(n);
    sync_empty();
  endtask

  task automatic queue_hash(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                            input logic [63:0] d, input logic [31:0] n);
    queue_nonce(n);
    wq.push_back(a); wq.push_back(b); wq.push_back(c); wq.push_back(d);
  endtask

  task automatic drain(input string name, input int max);
    int k;
    k = 0;
    while (!(wq.size() == 0 && eh.size() == 0 && nq.size() == 0 &&
             hash_count == 32'(hashes_m) && !found_valid) && k < max) begin
      tick();
      k++;
    end
    if (k >= max) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: hash_count %0d model %0d, %0d winners still pending", name, hash_count, hashes_m, eh.size());
    end
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_valid"}, {255'd0, found_valid}, 256'd0);
    chk({name, "_hash_count"}, {224'd0, hash_count}, 256'd0);
    chk({name, "_found_count"}, {224'd0, found_count}, 256'd0);
    chk({name, "_overflow"}, {255'd0, overflow_err}, 256'd0);
    chk({name, "_stall"}, {255'd0, heavy_hash_out_re}, 256'd0);
    chk({name, "_nonce_re"}, {255'd0, nonce_fifo_re}, 256'd0);
    chk({name, "_found_hash"}, found_hash, 256'd0);
    chk({name, "_found_nonce"}, {224'd0, found_nonce}, 256'd0);
  endtask

  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                              input logic [63:0] d, input logic [255:0] t, input logic [31:0] n,
                              input bit win);
    vec_t v;
    v.w0 = a; v.w1 = b; v.w2 = c; v.w3 = d; v.tgt = t; v.n = n; v.win = win;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc0;
    int start_cyc;
    int h0;
    logic [255:0] t;

    vecs[0] = mk(64'h1, 64'h2, 64'h3, 64'h4, '1, 32'hDEADBEEF, 1'b1);
    vecs[1] = mk(64'h5, 64'h6, 64'h7, 64'h8, '0, 32'd10, 1'b0);
    vecs[2] = mk(64'h9, 64'hA, 64'hB, 64'hC, '0, 32'd11, 1'b0);
    vecs[3] = mk(64'hD, 64'hE, 64'hF, 64'h10, '0, 32'd12, 1'b0);
    vecs[4] = mk(64'hFF, 64'h0, 64'h0, 64'h0, 256'hFF, 32'd13, 1'b1);
    vecs[5] = mk(64'h100, 64'h0, 64'h0, 64'h0, 256'hFF, 32'd14, 1'b0);
    vecs[6] = mk(64'h0, 64'h1, 64'h0, 64'h0, {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 32'd15, 1'b0);
    vecs[7] = mk('1, '1, '1, 64'h7, {64'h8, 192'd0}, 32'd16, 1'b1);

    rst = 1'b0;
    heavy_hash_out_data = '0; heavy_hash_out_we = 1'b0;
    nonce = '0; nonce_fifo_empty = 1'b1;
    target_we = 1'b0; target_addr = '0; target_din = '0;
    found_ack = 1'b0;
    #1;
    check_reset_state("reset");
    tick(); tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      fc0 = founds_m;
      set_target(vecs[i].tgt);
      queue_hash(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3, vecs[i].n);
      start_cyc = cyc + 1;
      drain("vec", 60);
      // First word pushed one edge before it can be popped, then 7 cycles to report.
      if (i == 0) chk("win_latency", 256'(rise_cyc - start_cyc), 256'd8);
      chk("vec_hash_count", {224'd0, hash_count}, 256'(hashes_m));
      chk("vec_found_count", {224'd0, found_count}, 256'(founds_m));
      chk("vec_win", 256'(founds_m - fc0), {255'd0, vecs[i].win});
      chk("vec_nonce_reads", 256'(re_pulses), 256'(hashes_m));
    end

    // Nonce FIFO withheld while three hashes stream in under backpressure.
    set_target('1);
    h0 = hashes_m;
    hold_empty = 1'b1;
    for (int k = 0; k < 3; k++)
      queue_hash(64'h100 + 64'(k * 4), 64'h101 + 64'(k * 4), 64'h102 + 64'(k * 4),
                 64'h103 + 64'(k * 4), 32'hA000 + 32'(k));
    for (int k = 0; k < 20; k++) tick();
    chk("stall_asserted", {255'd0, heavy_hash_out_re}, 256'd1);
    chk("stall_no_overflow", {255'd0, overflow_err}, 256'd0);
    hold_empty = 1'b0;
    sync_empty();
    drain("stall", 200);
    chk("stall_hashes", 256'(hashes_m - h0), 256'd3);
    chk("stall_hash_count", {224'd0, hash_count}, 256'(hashes_m));
    chk("stall_no_overflow_end", {255'd0, overflow_err}, 256'd0);

    // Overflow: hold the FSM in REPORT and push nine words ignoring the stall.
    auto_ack = 1'b0;
    queue_hash(64'h11, 64'h22, 64'h33, 64'h44, 32'hB0);
    for (int k = 0; k < 60 && !found_valid; k++) tick();
    chk("ovf_setup_valid", {255'd0, found_valid}, 256'd1);
    queue_nonce(32'hB1);
    queue_nonce(32'hB2);
    auto_drive = 1'b0;
    for (int k = 0; k < 9; k++) begin
      heavy_hash_out_we = 1'b1;
      heavy_hash_out_data = 64'hC00 + 64'(k);
      if (k < 8) model_word(heavy_hash_out_data);
      tick();
    end
    heavy_hash_out_we = 1'b0;
    tick();
    chk("overflow_set", {255'd0, overflow_err}, 256'd1);
    auto_drive = 1'b1;
    auto_ack = 1'b1;
    drain("ovf", 200);
    queue_hash(64'hD0, 64'hD1, 64'hD2, 64'hD3, 32'hB3);
    drain("ovf_after", 100);
    chk("ovf_hash_count", {224'd0, hash_count}, 256'(hashes_m));
    chk("ovf_found_count", {224'd0, found_count}, 256'(founds_m));
    chk("overflow_sticky", {255'd0, overflow_err}, 256'd1);

    // Reset with two words of a hash already collected.
    auto_drive = 1'b0;
    for (int k = 0; k < 2; k++) begin
      heavy_hash_out_we = 1'b1;
      heavy_hash_out_data = 64'hEE0 + 64'(k);
      tick();
    end
    heavy_hash_out_we = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_reset_state("midreset");
    model_reset();
    sync_empty();
    tick(); tick();
    rst = 1'b1;
    auto_drive = 1'b1;
    tick();
    queue_hash(64'hF1, 64'hF2, 64'hF3, 64'hF4, 32'hFACE);
    drain("post_reset", 60);
    chk("post_reset_hash_count", {224'd0, hash_count}, 256'd1);
    chk("post_reset_found_count", {224'd0, found_count}, 256'd1);

    // Randomized batches with random targets, nonce-FIFO gaps and ack delays.
    rand_ack = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 8; j++) t[j*32 +: 32] = $urandom;
      set_target(t);
      rand_empty = 1'b1;
      for (int h = 0; h < 5; h++)
        queue_hash({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom);
      drain("random", 3000);
      rand_empty = 1'b0;
      hold_empty = 1'b0;
      sync_empty();
      chk("rand_hash_count", {224'd0, hash_count}, 256'(hashes_m));
      chk("rand_found_count", {224'd0, found_count}, 256'(founds_m));
    end
    chk("rand_no_overflow", {255'd0, overflow_err}, 256'd0);
    chk("rand_nonce_reads", 256'(re_pulses), 256'(hashes_m));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
